pad_stream_bridge: RTL
======================

Name: pad_stream_bridge

Overview:
- Parametrised successor to the divider's fixed 8-bit pad-side FIFO interface.
- Sits directly behind the pad ring, between the pad nets (push_in, data_in_in, sign, select, data_out_out, sign_out, pull_out) and the divider core.
- Input side: assembles IO_WIDTH-bit beats into a mode-dependent operand word and hands it to the core over valid/ready.
- Output side: serialises core results back into IO_WIDTH-bit beats on the pads, with a per-beat pull_out strobe.

Parameters:
- IO_WIDTH, 8, pad data bus width per beat.
- IN_WORD_WIDTH, 64, full operand word width; must be a multiple of IO_WIDTH.
- SHORT_BEATS, 4, beats per word when select=0 (divr2 mode); range 1..IN_WORD_WIDTH/IO_WIDTH.
- OUT_WORD_WIDTH, 32, result word width; must be a multiple of IO_WIDTH.

Ports:
- clk  in  1  clock (single domain).
- rst_n  in  1  reset, asynchronous assert, active-low.
- push_in  in  1  pad strobe: data_in_in valid this cycle.
- data_in_in  in  IO_WIDTH  pad input beat.
- sign  in  1  operand sign; sampled on beat 0.
- select  in  1  mode, sampled on beat 0: 0 = divr2 (SHORT_BEATS beats), 1 = fp32 (IN_WORD_WIDTH/IO_WIDTH beats).
- op_valid  out  1  assembled operand word available.
- op_ready  in  1  core accepts the word.
- op_data  out  IN_WORD_WIDTH  assembled word.
- op_sign  out  1  sign captured with the word.
- op_mode  out  1  select captured with the word.
- res_valid  in  1  core result available.
- res_ready  out  1  bridge can accept a result.
- res_data  in  OUT_WORD_WIDTH  result word.
- res_sign  in  1  result sign.
- data_out_out  out  IO_WIDTH  pad output beat.
- sign_out  out  1  result sign, held for all beats of a word.
- pull_out  out  1  high on each cycle that data_out_out carries a valid beat.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst_n=0) values:
  - op_valid=0, op_data=0, op_sign=0, op_mode=0.
  - res_ready=0 while in reset; 1 in the first cycle after release.
  - data_out_out=0, sign_out=0, pull_out=0, ovf_err=0.
  - Beat counters cleared; any partial word in either direction is discarded.
- Input assembler:
  - Beat counter plus assembly register. A push_in cycle writes data_in_in into slice [k*IO_WIDTH +: IO_WIDTH], where k is the beat index (LSB-first).
  - On beat 0, sign and select are latched. They are ignored on later beats; a mode change mid-word has no effect.
  - The word is complete on beat N-1, where N = SHORT_BEATS (mode 0) or IN_WORD_WIDTH/IO_WIDTH (mode 1).
  - In mode 0, bits above SHORT_BEATS*IO_WIDTH are zero.
- Operand handoff:
  - A completed word transfers to the holding register (op_data/op_sign/op_mode). op_valid rises the cycle after the final beat.
  - op_valid stays high, with held data, until a cycle where op_valid && op_ready; it then drops next cycle unless a new word loads simultaneously.
  - Assembly of the next word proceeds while op_valid is pending.
- Final beat arriving while op_valid is pending:
  - If op_ready=1 in that same cycle: the old word is consumed, the new word loads, and op_valid stays 1. No error.
  - If op_ready=0: the new word is dropped, the holding register is unchanged, ovf_err is set (sticky until reset), and the assembly counter returns to 0.
- Output FSM states: IDLE, SEND (plus CHK when the optional feature is compiled in).
  - IDLE: res_ready=1, pull_out=0. On res_valid && res_ready, latch res_data/res_sign and go to SEND.
  - SEND: res_ready=0, pull_out=1. data_out_out = beat j of the latched word (LSB-first), for j = 0..OUT_WORD_WIDTH/IO_WIDTH-1, one per cycle; sign_out = latched sign.
  - After the last beat: go to IDLE (or CHK).
  - The first beat appears the cycle after the handshake. Words are always separated by at least one pull_out=0 cycle, which serves as the word delimiter.
  - In IDLE, data_out_out and sign_out hold their last values.
- Input and output paths are independent and may run concurrently.

Optional Feature:
- Macro: PAD_BRIDGE_CHECKBYTE_EN.
- Defined: after the last data beat, the FSM enters CHK for one cycle.
  - pull_out=1; data_out_out = XOR of all data beats of the word; sign_out held.
  - Then back to IDLE.
- Undefined: CHK state absent; SEND returns straight to IDLE.

Test Plan:
1. select=1, sign=1, push 0x01..0x08 on consecutive cycles, op_ready=0.
   -> op_valid=1 the cycle after 0x08; op_data=0x0807060504030201, op_sign=1, op_mode=1; held until op_ready=1.
2. select=0, push 0xAA,0xBB,0xCC,0xDD; toggle select on beat 2.
   -> op_data=0x00000000DDCCBBAA, op_mode=0.
3. res_valid=1, res_data=0x12345678, res_sign=1.
   -> res_ready=0 next cycle; pull_out=1 for 4 cycles with 0x78,0x56,0x34,0x12; sign_out=1; then pull_out=0 and res_ready=1.
4. op_ready=0, push two full fp32 words.
   -> second word dropped, ovf_err=1, op_data keeps the first word.
   -> Repeat with op_ready=1 on the second word's final beat: op_valid stays 1, new data, ovf_err stays 0.
5. Push 3 beats, pulse rst_n low mid-word, then push 0x11..0x88 (8 beats).
   -> op_data=0x8877665544332211; no residue from the partial word.
6. With PAD_BRIDGE_CHECKBYTE_EN defined, repeat scenario 3.
   -> a 5th pull_out beat carries 0x08.
   -> Without the macro: exactly 4 beats.

Source files
------------

// File: rtl/pad_stream_bridge.sv
// Pad-side bridge: packs IO_WIDTH-bit pad beats into operand words for the divider core and serialises results back out to the pads.
// The optional trailing XOR check beat is enabled by defining PAD_BRIDGE_CHECKBYTE_EN.
module pad_stream_bridge #(
  parameter int IO_WIDTH       = 8,
  parameter int IN_WORD_WIDTH  = 64,
  parameter int SHORT_BEATS    = 4,
  parameter int OUT_WORD_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_in,
  input  logic [IO_WIDTH-1:0]       data_in_in,
  input  logic                      sign,
  input  logic                      select,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [IN_WORD_WIDTH-1:0]  op_data,
  output logic                      op_sign,
  output logic                      op_mode,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [OUT_WORD_WIDTH-1:0] res_data,
  input  logic                      res_sign,
  output logic [IO_WIDTH-1:0]       data_out_out,
  output logic                      sign_out,
  output logic                      pull_out,
  output logic                      ovf_err,
  output logic [1:0]                dbg_out_state
);

  localparam int LONG_BEATS = IN_WORD_WIDTH / IO_WIDTH;
  localparam int OUT_BEATS  = OUT_WORD_WIDTH / IO_WIDTH;
  localparam int ICW = (LONG_BEATS > 1) ? $clog2(LONG_BEATS) : 1;
  localparam int OCW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

  // Handshakes (op_*, res_*): a word moves on any rising clk edge where valid && ready;
  // the source holds valid and data stable until that edge, and ready never waits on valid.

  // ---------------- input assembler ----------------
  logic [ICW-1:0]           in_beat_q;
  logic [IN_WORD_WIDTH-1:0] asm_q, asm_next;
  logic                     mode_q, sign_q;
  logic                     cur_mode, cur_sign, last_beat, load_op, drop_op;

  always_comb begin
    cur_mode = (in_beat_q == '0) ? select : mode_q;
    cur_sign = (in_beat_q == '0) ? sign : sign_q;
    // Beat 0 starts from zero so short words carry no stale upper bits.
    asm_next = (in_beat_q == '0) ? '0 : asm_q;
    for (int i = 0; i < LONG_BEATS; i++) begin
      if (in_beat_q == ICW'(i)) asm_next[i*IO_WIDTH +: IO_WIDTH] = data_in_in;
    end
    last_beat = push_in && (cur_mode ? (in_beat_q == ICW'(LONG_BEATS - 1))
                                     : (in_beat_q == ICW'(SHORT_BEATS - 1)));
    load_op   = last_beat && (!op_valid || op_ready);
    drop_op   = last_beat && op_valid && !op_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_beat_q <= '0;
      asm_q     <= '0;
      mode_q    <= 1'b0;
      sign_q    <= 1'b0;
    end else if (push_in) begin
      asm_q     <= asm_next;
      mode_q    <= cur_mode;
      sign_q    <= cur_sign;
      in_beat_q <= last_beat ? '0 : in_beat_q + ICW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_data  <= '0;
      op_sign  <= 1'b0;
      op_mode  <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      if (load_op) begin
        op_valid <= 1'b1;
        op_data  <= asm_next;
        op_sign  <= cur_sign;
        op_mode  <= cur_mode;
      end else if (op_valid && op_ready) begin
        op_valid <= 1'b0;
      end
      if (drop_op) ovf_err <= 1'b1;
    end
  end

  // ---------------- output serialiser ----------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
`ifdef PAD_BRIDGE_CHECKBYTE_EN
    , S_CHK = 2'd2
`endif
  } out_state_t;

  out_state_t                state_q, state_next;
  logic [OUT_WORD_WIDTH-1:0] shift_q;
  logic [OCW-1:0]            out_beat_q;
  logic [IO_WIDTH-1:0]       out_q, xor_q;
  logic                      sign_out_q;
  logic                      send_last;

  assign send_last = (out_beat_q == OCW'(OUT_BEATS - 1));

  always_comb begin
    state_next = state_q;
    res_ready  = 1'b0;
    pull_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so the core sees no ready while the bridge is held in reset.
        res_ready = rst_n;
        if (res_valid && rst_n) state_next = S_SEND;
      end
      S_SEND: begin
        pull_out = 1'b1;
`ifdef PAD_BRIDGE_CHECKBYTE_EN
        if (send_last) state_next = S_CHK;
`else
        if (send_last) state_next = S_IDLE;
`endif
      end
`ifdef PAD_BRIDGE_CHECKBYTE_EN
      S_CHK: begin
        pull_out   = 1'b1;
        state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_next;
  end

  // The pad beat is registered so it stays put in IDLE between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      out_beat_q <= '0;
      out_q      <= '0;
      xor_q      <= '0;
      sign_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (res_valid) begin
            out_q      <= res_data[IO_WIDTH-1:0];
            xor_q      <= res_data[IO_WIDTH-1:0];
            shift_q    <= res_data >> IO_WIDTH;
            sign_out_q <= res_sign;
            out_beat_q <= '0;
          end
        end
        S_SEND: begin
          if (!send_last) begin
            out_q      <= shift_q[IO_WIDTH-1:0];
            xor_q      <= xor_q ^ shift_q[IO_WIDTH-1:0];
            shift_q    <= shift_q >> IO_WIDTH;
            out_beat_q <= out_beat_q + OCW'(1);
          end
`ifdef PAD_BRIDGE_CHECKBYTE_EN
          else begin
            out_q <= xor_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign data_out_out  = out_q;
  assign sign_out      = sign_out_q;
  assign dbg_out_state = state_q;

endmodule
